irq_requester: RTL

- Requester-side front end for the CPU's three-line external interrupt interface.
- Per channel: synchronises and debounces a raw push-button level, then turns each debounced press into a level request on `break_o[n]`.
- Holds each request until the CPU acknowledges it on `ack_i[n]`, which is the interrupt block's per-channel in-service signal.
- Keeps one further press per channel queued while that channel is being serviced, and counts presses that cannot be kept.
- Sits between the board buttons and the `break1`/`break2`/`break3` inputs of the CPU top level.

---
 rtl/irq_requester.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/irq_requester.sv
// irq_requester: button-to-interrupt front end for the CPU's external IRQ lines.
// Each channel synchronises and debounces a raw key, and turns each debounced
// press into a level request held until the CPU acknowledges it. One extra
// press can be queued while the channel is in service, and presses that cannot
// be kept are counted in a shared, saturating drop counter.

module irq_req_ch #(
   parameter int DEBOUNCE = 16,
   parameter int CNT_W    = $clog2(DEBOUNCE+1)
) (
   input  logic clk,
   input  logic RST,
   input  logic key_i,
   input  logic ack_i,
   output logic break_o,
   output logic pending_o,
   output logic drop_o
);

   typedef enum logic [1:0] {IDLE, PEND, SERV} state_t;

   logic             sync1_q, s_q, db_q, dbp_q;
   logic [CNT_W-1:0] cnt_q;
   state_t           state_q, state_d;
   logic             queued_q, queued_d;
   logic             break_q, pend_q;
   logic             rise;

   // Two-flop synchroniser, then a debounce counter that flips the level only
   // after DEBOUNCE consecutive disagreeing samples.
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
         db_q    <= 1'b0;
         dbp_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= key_i;
         s_q     <= sync1_q;
         dbp_q   <= db_q;
         if (s_q == db_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_W'(DEBOUNCE-1)) begin
            db_q  <= s_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Only the debounced rising edge is a press; releases are ignored.
   assign rise = db_q & ~dbp_q;

   // Request / in-service / queue state; drop_o flags a press that is lost.
   always_comb begin
      state_d  = state_q;
      queued_d = queued_q;
      drop_o   = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) state_d = PEND;
         end
         PEND: begin
            if (ack_i) begin
               state_d  = SERV;
               queued_d = queued_q | rise;
               drop_o   = queued_q & rise;
            end else if (rise) begin
               drop_o = 1'b1;   // merged into the request already raised
            end
         end
         SERV: begin
            if (ack_i) begin
               if (rise) begin
                  if (queued_q) drop_o   = 1'b1;
                  else          queued_d = 1'b1;
               end
            end else if (queued_q) begin
               // Queued press becomes the new request; a simultaneous press
               // takes its place in the queue.
               state_d  = PEND;
               queued_d = rise;
            end else begin
               state_d  = rise ? PEND : IDLE;
               queued_d = 1'b0;
            end
         end
         default: begin
            state_d  = IDLE;
            queued_d = 1'b0;
         end
      endcase
   end

   // State register with registered request and pending outputs.
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state_q  <= IDLE;
         queued_q <= 1'b0;
         break_q  <= 1'b0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         queued_q <= queued_d;
         break_q  <= (state_d == PEND);
         pend_q   <= (state_d == PEND) | queued_d;
      end
   end

   assign break_o   = break_q;
   assign pending_o = pend_q;

endmodule

module irq_requester #(
   parameter int N_CH     = 3,
   parameter int DEBOUNCE = 16,
   parameter int CNT_W    = $clog2(DEBOUNCE+1)
) (
   input  logic            clk,
   input  logic            RST,
   input  logic [N_CH-1:0] key_i,
   input  logic [N_CH-1:0] ack_i,
   output logic [N_CH-1:0] break_o,
   output logic [N_CH-1:0] pending_o,
   output logic [7:0]      drop_cnt
);

   logic [N_CH-1:0] drops;
   logic [8:0]      sum;
   logic [7:0]      drop_d, drop_q;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      irq_req_ch #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_ch (
         .clk      (clk),
         .RST      (RST),
         .key_i    (key_i[g]),
         .ack_i    (ack_i[g]),
         .break_o  (break_o[g]),
         .pending_o(pending_o[g]),
         .drop_o   (drops[g])
      );
   end

   // Add this cycle's drops from all channels and clamp at 255.
   always_comb begin
      sum = {1'b0, drop_q};
      for (int i = 0; i < N_CH; i++) sum = sum + 9'(drops[i]);
      drop_d = sum[8] ? 8'hFF : sum[7:0];
   end

   // Drop counter register.
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) drop_q <= 8'h00;
      else      drop_q <= drop_d;
   end

   assign drop_cnt = drop_q;

endmodule
